// File: rtl/lcd_bus_capture.sv
// Snoops an HD44780-style LCD write bus into a 32-char shadow buffer; buffer update 1 clk after the lcd_e fall sample.
// Transfers arriving during a clear sweep are dropped and flagged via overrun; LCD_CAP_SYNC_EN adds a 2-flop input synchronizer.
module lcd_bus_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic [7:0] lcd_d,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       dirty,
  input  logic       dirty_clr,
  output logic       overrun
);

  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } state_e;

  logic       e_s;
  logic       rs_s;
  logic [7:0] d_s;

`ifdef LCD_CAP_SYNC_EN
  logic [1:0] e_sync_q;
  logic [1:0] rs_sync_q;
  logic [7:0] d_sync1_q;
  logic [7:0] d_sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_sync_q  <= 2'b00;
      rs_sync_q <= 2'b00;
      d_sync1_q <= 8'h00;
      d_sync2_q <= 8'h00;
    end else begin
      e_sync_q  <= {e_sync_q[0], lcd_e};
      rs_sync_q <= {rs_sync_q[0], lcd_rs};
      d_sync1_q <= lcd_d;
      d_sync2_q <= d_sync1_q;
    end
  end

  assign e_s  = e_sync_q[1];
  assign rs_s = rs_sync_q[1];
  assign d_s  = d_sync2_q;
`else
  assign e_s  = lcd_e;
  assign rs_s = lcd_rs;
  assign d_s  = lcd_d;
`endif

  state_e     state_q, state_d;
  logic [4:0] sweep_idx_q, sweep_idx_d;
  logic [4:0] ac_q, ac_d;
  logic       inc_q, inc_d;
  logic       e_q;
  logic       dirty_q, dirty_d;
  logic       overrun_q, overrun_d;
  logic [7:0] rd_data_q;
  logic [7:0] buf_q [32];

  logic       fall;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_dat;

  assign fall = e_q & ~e_s;

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    ac_d        = ac_q;
    inc_d       = inc_q;
    wr_en       = 1'b0;
    wr_addr     = ac_q;
    wr_dat      = d_s;
    overrun_d   = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          if (rs_s) begin
            wr_en = 1'b1;
            ac_d  = inc_q ? ac_q + 5'd1 : ac_q - 5'd1;
          end else begin
            // Priority decode: the highest set bit selects the command.
            casez (d_s)
              8'b1???????: ac_d = {d_s[6], d_s[3:0]};
              8'b01??????: ;
              8'b001?????: ;
              8'b0001????: begin
                if (!d_s[3]) begin
                  ac_d = d_s[2] ? ac_q + 5'd1 : ac_q - 5'd1;
                end
              end
              8'b00001???: ;
              8'b000001??: inc_d = d_s[1];
              8'b0000001?: ac_d = 5'd0;
              8'b00000001: begin
                ac_d        = 5'd0;
                inc_d       = 1'b1;
                sweep_idx_d = 5'd0;
                state_d     = ST_SWEEP;
              end
              default: ;
            endcase
          end
        end
      end
      ST_SWEEP: begin
        wr_en       = 1'b1;
        wr_addr     = sweep_idx_q;
        wr_dat      = SPACE;
        sweep_idx_d = sweep_idx_q + 5'd1;
        if (fall) begin
          overrun_d = 1'b1;
        end
        if (sweep_idx_q == 5'd31) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A set in the same cycle as dirty_clr must win.
    dirty_d = wr_en | (dirty_q & ~dirty_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= 5'd0;
      ac_q        <= 5'd0;
      inc_q       <= 1'b1;
      e_q         <= 1'b0;
      dirty_q     <= 1'b0;
      overrun_q   <= 1'b0;
      rd_data_q   <= SPACE;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ac_q        <= ac_d;
      inc_q       <= inc_d;
      e_q         <= e_s;
      dirty_q     <= dirty_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= buf_q[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        buf_q[i] <= SPACE;
      end
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == ST_SWEEP);
  assign dirty   = dirty_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Directed bench for lcd_bus_capture (default build, no input synchronizer).
module tb_lcd_bus_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [7:0] lcd_d = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy;
  logic       dirty;
  logic       dirty_clr = 1'b0;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_bus_capture dut (
    .clk       (clk),
    .reset     (reset),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_d     (lcd_d),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .dirty     (dirty),
    .dirty_clr (dirty_clr),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus write: lcd_e high for one cycle then low; dirty_clr optionally coincides with the update cycle.
  task automatic xfer(input logic rs, input logic [7:0] d, input logic clr);
    @(negedge clk);
    lcd_rs = rs;
    lcd_d  = d;
    lcd_e  = 1'b1;
    @(negedge clk);
    lcd_e     = 1'b0;
    dirty_clr = clr;
    @(negedge clk);
    dirty_clr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         cnt;
    logic       first_busy;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_data", rd_data, 8'h20);
    check("rst_busy", busy, 0);
    check("rst_dirty", dirty, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Data 0x41, 0x42 at ac 0,1; then ac must be 2
    xfer(1'b1, 8'h41, 1'b0);
    xfer(1'b1, 8'h42, 1'b0);
    check("dirty_after_write", dirty, 1);
    rd(5'd0, v); check("buf0_41", v, 8'h41);
    rd(5'd1, v); check("buf1_42", v, 8'h42);
    xfer(1'b1, 8'h43, 1'b0);
    rd(5'd2, v); check("ac_is_2", v, 8'h43);

    // Set address 0xC5 -> 21
    xfer(1'b0, 8'hC5, 1'b0);
    xfer(1'b1, 8'h5A, 1'b0);
    rd(5'd21, v); check("buf21_5A", v, 8'h5A);
    xfer(1'b1, 8'h5B, 1'b0);
    rd(5'd22, v); check("ac_is_22", v, 8'h5B);
    // Ignored commands, then cursor shift left
    xfer(1'b0, 8'h38, 1'b0);
    xfer(1'b0, 8'h0C, 1'b0);
    xfer(1'b0, 8'h18, 1'b0);
    xfer(1'b1, 8'h5C, 1'b0);
    rd(5'd23, v); check("ignored_cmds", v, 8'h5C);
    xfer(1'b0, 8'h10, 1'b0);
    xfer(1'b1, 8'h5D, 1'b0);
    rd(5'd23, v); check("cursor_shift_left", v, 8'h5D);
    xfer(1'b0, 8'h14, 1'b0);
    xfer(1'b1, 8'h5E, 1'b0);
    rd(5'd25, v); check("cursor_shift_right", v, 8'h5E);

    // Decrement mode wraps 0 -> 31
    xfer(1'b0, 8'h04, 1'b0);
    xfer(1'b0, 8'h80, 1'b0);
    xfer(1'b1, 8'h31, 1'b0);
    xfer(1'b1, 8'h32, 1'b0);
    rd(5'd0, v);  check("buf0_31", v, 8'h31);
    rd(5'd31, v); check("buf31_32_wrap", v, 8'h32);
    xfer(1'b0, 8'h02, 1'b0);
    xfer(1'b1, 8'h33, 1'b0);
    rd(5'd0, v); check("home", v, 8'h33);

    // Clear sweep with a strobe landing mid-sweep
    check("overrun_pre", overrun, 0);
    @(negedge clk);
    lcd_rs = 1'b0; lcd_d = 8'h01; lcd_e = 1'b1;
    @(negedge clk);
    lcd_e = 1'b0;
    check("busy_not_yet", busy, 0);
    cnt = 0;
    first_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busy;
      if (busy) cnt++;
      if (i == 4) begin lcd_rs = 1'b1; lcd_d = 8'h99; lcd_e = 1'b1; end
      if (i == 5) lcd_e = 1'b0;
    end
    check("busy_first_cycle", first_busy, 1);
    check("busy_cycles", cnt, 32);
    check("overrun_set", overrun, 1);
    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], v);
      check($sformatf("clear_buf%0d", a), v, 8'h20);
    end
    xfer(1'b1, 8'h61, 1'b0);
    xfer(1'b1, 8'h62, 1'b0);
    rd(5'd0, v); check("clr_ac0_drop_noeffect", v, 8'h61);
    rd(5'd1, v); check("clr_inc1", v, 8'h62);
    check("overrun_sticky", overrun, 1);

    // dirty_clr coinciding with a write, then alone
    check("dirty_before_clr", dirty, 1);
    xfer(1'b1, 8'h63, 1'b1);
    check("dirty_set_wins", dirty, 1);
    @(negedge clk); dirty_clr = 1'b1;
    @(negedge clk); dirty_clr = 1'b0;
    check("dirty_cleared", dirty, 0);
    rd(5'd2, v); check("buf2_63", v, 8'h63);

    // Reset in the middle of a clear sweep
    xfer(1'b0, 8'hC4, 1'b0);
    xfer(1'b1, 8'h7A, 1'b0);
    rd(5'd20, v); check("buf20_7A", v, 8'h7A);
    xfer(1'b0, 8'h01, 1'b0);
    repeat (9) @(negedge clk);
    check("busy_mid_sweep", busy, 1);
    reset = 1'b1;
    #1;
    check("reset_busy_async", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_dirty", dirty, 0);
    @(negedge clk);
    check("reset_rd_data", rd_data, 8'h20);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_pending_clear", busy, 0);
    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], v);
      check($sformatf("rst_buf%0d", a), v, 8'h20);
    end
    check("no_dirty_after_rst", dirty, 0);
    xfer(1'b1, 8'h77, 1'b0);
    rd(5'd0, v); check("rst_ac0", v, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
